// File: rtl/ifetch_pkg.sv
// Shared widths and the fetch-entry bundle for the fetch stage.
// Imported by the interface, the queue and the top.
package ifetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Memory-address and decode-handshake bundle of the fetch stage.
// master = fetch side, slave = memory/decode side.
interface instr_fetch_if;
  import ifetch_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with push/pop/flush.
// Flush wins over push and pop; storage clears on reset.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;

  assign pop     = pop_i & (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i & ~pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop & ~push_i)
      cnt_d = cnt_q - 1'b1;
  end

  // Pointers, count and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop)
        rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, redirect handling, queue to decode.
// IFETCH_ALIGN_CHECK_EN enables the misaligned-redirect fault/halt.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_fault
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] pc_q;
  logic              halted;
  logic              full;
  logic [CW-1:0]     count;
  logic              pop, push;
  fetch_entry_t      wentry, head;

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = ~halted & (~full | pop) & ~redirect_valid;

  assign wentry.instr = bus.imem_data;
  assign wentry.pc    = pc_q;

  fetch_queue #(.DEPTH(QDEPTH)) u_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (full),
    .count_o (count)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic aligned;

  assign aligned     = (redirect_pc[1:0] == 2'b00);
  assign halted      = fault_q;
  assign fetch_fault = fault_q;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_q <= 1'b0;
    else if (redirect_valid)
      fault_q <= ~aligned;
  end

  // Fetch PC; a misaligned redirect leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else if (redirect_valid) begin
      if (aligned)
        pc_q <= redirect_pc;
    end else if (push)
      pc_q <= pc_q + PC_STEP;
  end
`else
  assign halted      = 1'b0;
  assign fetch_fault = 1'b0;

  // Fetch PC: redirect first, else advance on every enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else if (redirect_valid)
      pc_q <= redirect_pc;
    else if (push)
      pc_q <= pc_q + PC_STEP;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus stall,
// async-reset and redirect-alignment sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv;
  logic [31:0] rpc;
  logic        fault;
  int          checks = 0;
  int          failures = 0;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .fetch_fault    (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ea;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic r, logic [31:0] p, logic d,
                              logic v, logic [31:0] epc,
                              logic [31:0] ea);
    vec_t x;
    x.rv = r; x.rpc = p; x.rdy = d;
    x.ev = v; x.epc = epc; x.ea = ea;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // row: inputs this cycle, expected outputs seen this cycle
    vt[0]  = mk(0, 0, 1, 0, 32'h0,  32'h0);
    vt[1]  = mk(0, 0, 1, 1, 32'h0,  32'h4);
    vt[2]  = mk(0, 0, 1, 1, 32'h4,  32'h8);
    vt[3]  = mk(0, 0, 0, 1, 32'h8,  32'hC);
    vt[4]  = mk(0, 0, 0, 1, 32'h8,  32'h10);
    vt[5]  = mk(0, 0, 0, 1, 32'h8,  32'h10);
    vt[6]  = mk(0, 0, 0, 1, 32'h8,  32'h10);
    vt[7]  = mk(0, 0, 0, 1, 32'h8,  32'h10);
    vt[8]  = mk(0, 0, 1, 1, 32'h8,  32'h10);
    vt[9]  = mk(0, 0, 1, 1, 32'hC,  32'h14);
    vt[10] = mk(1, 32'h20, 1, 1, 32'h10, 32'h18);
    vt[11] = mk(0, 0, 1, 0, 32'h0,  32'h20);
    vt[12] = mk(1, 32'hFFFF_FFFC, 1, 1, 32'h20, 32'h24);
    vt[13] = mk(0, 0, 1, 0, 32'h0,  32'hFFFF_FFFC);
    vt[14] = mk(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0);
    vt[15] = mk(0, 0, 1, 1, 32'h0,  32'h4);

    rst_n = 1'b0;
    rv = 1'b0;
    rpc = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vt[i].ea);
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'h0);
      if (vt[i].ev) begin
        chk($sformatf("v%0d_pc", i), bus.out_pc, vt[i].epc);
        chk($sformatf("v%0d_instr", i), bus.out_instr,
            mem_word(vt[i].epc));
      end
      rv = vt[i].rv;
      rpc = vt[i].rpc;
      bus.out_ready = vt[i].rdy;
      @(negedge clk);
    end

    // async reset between edges, then stall from RESET_PC
    rv = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_pc", bus.out_pc, 32'h0);
    chk("arst_instr", bus.out_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall2_addr", bus.imem_addr, 32'h8);
    repeat (3) @(negedge clk);
    chk("stall5_valid", 32'(bus.out_valid), 32'h1);
    chk("stall5_addr", bus.imem_addr, 32'h8);
    chk("stall5_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'h1);
      chk($sformatf("drain%0d_pc", k), bus.out_pc, 32'(4 * k));
      chk($sformatf("drain%0d_instr", k), bus.out_instr,
          mem_word(32'(4 * k)));
      @(negedge clk);
    end

    // redirect alignment behaviour
    bus.out_ready = 1'b0;
    rv = 1'b1;
    rpc = 32'h30;
    @(negedge clk);
    rpc = 32'h6;
    @(negedge clk);
    rv = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_valid", 32'(bus.out_valid), 32'h0);
    chk("mis_addr", bus.imem_addr, 32'h30);
    @(negedge clk);
    chk("mis2_fault", 32'(fault), 32'h1);
    chk("mis2_valid", 32'(bus.out_valid), 32'h0);
    chk("mis2_addr", bus.imem_addr, 32'h30);
    rv = 1'b1;
    rpc = 32'h8;
    @(negedge clk);
    rv = 1'b0;
    chk("fix_fault", 32'(fault), 32'h0);
    chk("fix_valid", 32'(bus.out_valid), 32'h0);
    chk("fix_addr", bus.imem_addr, 32'h8);
    @(negedge clk);
    chk("fix2_valid", 32'(bus.out_valid), 32'h1);
    chk("fix2_pc", bus.out_pc, 32'h8);
    chk("fix2_instr", bus.out_instr, 32'h08090A0B);
`else
    chk("mis_fault", 32'(fault), 32'h0);
    chk("mis_valid", 32'(bus.out_valid), 32'h0);
    chk("mis_addr", bus.imem_addr, 32'h6);
    @(negedge clk);
    chk("mis2_valid", 32'(bus.out_valid), 32'h1);
    chk("mis2_pc", bus.out_pc, 32'h6);
    chk("mis2_instr", bus.out_instr, 32'h06070809);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
